// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   ADDR_W, INSTR_W, RESET_PC  ROM geometry and default reset PC
//   fetch_state_t              IDLE / RUN / HALT sequencer states
//   fetch_entry_t              one prefetch slot: {data, pc, err}
//   pc_misaligned()            true when a byte address is not word aligned
package fetch_pkg;

  localparam int                ADDR_W   = 14;
  localparam int                INSTR_W  = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] data;
    logic [ADDR_W-1:0]  pc;
    logic               err;
  } fetch_entry_t;

  // Only the two low address bits decide word alignment.
  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding fetch_entry_t slots between the ROM and the core.
// Latency: an entry pushed at edge N is visible on head in cycle N+1.
// Backpressure: push is ignored when full unless a pop happens the same cycle; flush empties it.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_entry at the next edge (if there is room)
//   push_entry   entry to write
//   pop          retire the head entry (ignored when empty)
//   flush        discard all entries; overrides push and pop
//   full, empty  occupancy flags
//   head         oldest entry (undefined content while empty)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2  // power of two, at least 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits are equal.
  logic [PW:0]  r_wr_ptr;
  logic [PW:0]  r_rd_ptr;
  fetch_entry_t r_mem [DEPTH];

  logic w_push_ok;
  logic w_pop_ok;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                 (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

  // A push into a full FIFO is fine when the head leaves in the same cycle:
  // the write lands in the slot being vacated.
  assign w_push_ok = push && (!full || pop);
  assign w_pop_ok  = pop && !empty;

  assign head = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
    end
  end

  // Storage needs no reset: slots are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push_ok && !flush) begin
      r_mem[r_wr_ptr[PW-1:0]] <= push_entry;
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Fetch sequencer: owns the fetch PC, samples the combinational ROM and queues words for the core.
// Latency: PC on im_addr in cycle N -> instr_valid in N+1; redirect in R -> first new instruction in R+2.
// Backpressure: instr_ready low fills the prefetch FIFO, then fetch_pc and im_addr hold until a pop.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   run_en                     1 = new fetches allowed
//   im_addr / im_dout          ROM byte address (fetch PC) / same-cycle ROM data
//   redirect_valid/redirect_pc PC change request; flushes the prefetch FIFO
//   instr_valid/instr_ready    handshake towards the core control FSM
//   instr_data/instr_pc        head instruction and its byte address
//   instr_err                  head came from a misaligned fetch PC
module imem_fetch_unit #(
  parameter logic [fetch_pkg::ADDR_W-1:0] RESET_PC   = fetch_pkg::RESET_PC,
  parameter int                           FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run_en,
  output logic [fetch_pkg::ADDR_W-1:0]  im_addr,
  input  logic [fetch_pkg::INSTR_W-1:0] im_dout,
  input  logic                         redirect_valid,
  input  logic [fetch_pkg::ADDR_W-1:0]  redirect_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [fetch_pkg::INSTR_W-1:0] instr_data,
  output logic [fetch_pkg::ADDR_W-1:0]  instr_pc,
  output logic                         instr_err
);

  import fetch_pkg::*;

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  fetch_entry_t      r_hold;

  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_push;
  logic         w_fetch_en;
  logic         w_misaligned;
  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;
  fetch_entry_t w_out;

  assign w_misaligned = pc_misaligned(r_fetch_pc[1:0]);
  assign im_addr      = r_fetch_pc;

  // A misaligned PC never reaches the core as an instruction: the slot is
  // pushed with zero data and the error flag so the core can trap on it.
  always_comb begin
    w_push_entry      = '0;
    w_push_entry.data = w_misaligned ? '0 : im_dout;
    w_push_entry.pc   = r_fetch_pc;
    w_push_entry.err  = w_misaligned;
  end

  // ---------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = !w_empty && instr_ready;
    // Fetching starts in the same cycle run_en rises, so the first entry is
    // valid one cycle after run_en; HALT blocks fetch until a redirect.
    w_fetch_en  = run_en && (r_state != HALT);
    // A redirect cycle never pushes: the ROM word belongs to the old path.
    w_push      = w_fetch_en && !redirect_valid && (!w_full || w_pop);

    if (redirect_valid) begin
      // Redirect is honoured in every state and is the only exit from HALT.
      w_state_nxt = run_en ? RUN : IDLE;
    end else begin
      case (r_state)
        IDLE, RUN: begin
          if (w_push && w_misaligned) w_state_nxt = HALT;
          else if (run_en)            w_state_nxt = RUN;
          else                        w_state_nxt = IDLE;
        end
        HALT:    w_state_nxt = HALT;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Fetch PC: wraps modulo 2^ADDR_W; holds on a misaligned push so the
  // faulting address stays visible until the core redirects.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_push && !w_misaligned) begin
      r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
    end
  end

  // ---------------------------------------------------------------------
  // Prefetch FIFO. A pop handshake in a redirect cycle is lost with the
  // flush; the core re-fetches from the new target.
  // ---------------------------------------------------------------------
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .flush      (redirect_valid),
    .full       (w_full),
    .empty      (w_empty),
    .head       (w_head)
  );

  // While the FIFO is empty the data/pc outputs keep showing the last head
  // the core saw rather than stale storage contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (!w_empty) begin
      r_hold <= w_head;
    end
  end

  assign w_out       = w_empty ? r_hold : w_head;
  assign instr_valid = !w_empty;
  assign instr_data  = w_out.data;
  assign instr_pc    = w_out.pc;
  assign instr_err   = !w_empty && w_head.err;

endmodule
